// File: rtl/ei_axi4_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ei_axi4_pkg
// Shared definitions for the AXI4 write-path arbiter and its helpers:
//   - arb_state_e   : arbiter FSM states (IDLE/ADDR/DATA/RESP)
//   - AW_*          : bit offsets/widths inside the packed AW payload
//                     {awid, awaddr, awlen[7:0], awsize[2:0], awburst[1:0]}
//   - BRESP_*       : AXI4 write response codes
//   - len_mismatch  : W burst length check for a single beat
// ---------------------------------------------------------------------------
package ei_axi4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  // AW payload layout, LSB first: awburst, awsize, awlen, then awaddr and awid.
  localparam int AW_BURST_LSB = 0;
  localparam int AW_BURST_W   = 2;
  localparam int AW_SIZE_LSB  = 2;
  localparam int AW_SIZE_W    = 3;
  localparam int AW_LEN_LSB   = 5;
  localparam int AW_LEN_W     = 8;
  localparam int AW_ADDR_LSB  = 13;
  // Width of the fixed (non-parameterised) fields: len + size + burst.
  localparam int AW_FIXED_W   = AW_LEN_W + AW_SIZE_W + AW_BURST_W;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  // A beat is malformed if wlast arrives early/late relative to awlen:
  // the last beat must be beat number awlen, and beat awlen must be last.
  function automatic logic len_mismatch(input logic       wlast,
                                        input logic [7:0] beat_cnt,
                                        input logic [7:0] awlen);
    return wlast ? (beat_cnt != awlen) : (beat_cnt == awlen);
  endfunction

endpackage

// File: rtl/ei_axi4_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// ei_axi4_wr_arbiter_if
// Bundle of all handshake/payload signals around the write arbiter.
//   s_*  : NUM_MST upstream master ports (master i at bit/slice i)
//   m_*  : single downstream slave port
// Modports:
//   slave  : the arbiter's view (it is the slave of the s_* ports and
//            drives the m_* ports toward the downstream slave)
//   master : the environment's view (upstream masters + downstream slave)
// ---------------------------------------------------------------------------
interface ei_axi4_wr_arbiter_if
  import ei_axi4_pkg::*;
#(
  parameter int NUM_MST    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  localparam int AW_W = ID_WIDTH + ADDR_WIDTH + AW_FIXED_W;
  localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8;
  localparam int B_W  = ID_WIDTH + 2;

  // upstream masters
  logic [NUM_MST-1:0]      s_awvalid;
  logic [NUM_MST-1:0]      s_awready;
  logic [NUM_MST*AW_W-1:0] s_aw;
  logic [NUM_MST-1:0]      s_wvalid;
  logic [NUM_MST-1:0]      s_wready;
  logic [NUM_MST-1:0]      s_wlast;
  logic [NUM_MST*W_W-1:0]  s_w;
  logic [NUM_MST-1:0]      s_bvalid;
  logic [NUM_MST-1:0]      s_bready;
  logic [B_W-1:0]          s_b;

  // downstream slave
  logic                    m_awvalid;
  logic                    m_awready;
  logic [AW_W-1:0]         m_aw;
  logic                    m_wvalid;
  logic                    m_wready;
  logic                    m_wlast;
  logic [W_W-1:0]          m_w;
  logic                    m_bvalid;
  logic                    m_bready;
  logic [B_W-1:0]          m_b;

  modport slave (
    input  s_awvalid, s_aw, s_wvalid, s_wlast, s_w, s_bready,
    input  m_awready, m_wready, m_bvalid, m_b,
    output s_awready, s_wready, s_bvalid, s_b,
    output m_awvalid, m_aw, m_wvalid, m_wlast, m_w, m_bready
  );

  modport master (
    output s_awvalid, s_aw, s_wvalid, s_wlast, s_w, s_bready,
    output m_awready, m_wready, m_bvalid, m_b,
    input  s_awready, s_wready, s_bvalid, s_b,
    input  m_awvalid, m_aw, m_wvalid, m_wlast, m_w, m_bready
  );

endinterface

// File: rtl/ei_axi4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ei_axi4_rr_arbiter
// Combinational round-robin picker: returns the first set request bit
// searching upward from rr_ptr and wrapping at NUM_REQ-1.
// Ports:
//   req       in  NUM_REQ  request vector
//   rr_ptr    in  IDX_W    highest-priority index this round
//   gnt       out NUM_REQ  one-hot winner (0 when no request)
//   gnt_idx   out IDX_W    winner index (0 when no request)
//   gnt_valid out 1        at least one request present
// ---------------------------------------------------------------------------
module ei_axi4_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid
);
  // One extra bit so rr_ptr + offset never overflows before the wrap.
  localparam int SUM_W = IDX_W + 1;

  // Candidate gi is the requester gi positions above rr_ptr (mod NUM_REQ).
  logic [IDX_W-1:0]   cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [SUM_W-1:0] sum;
      assign sum          = {1'b0, rr_ptr} + SUM_W'(gi);
      assign cand_idx[gi] = (sum >= SUM_W'(NUM_REQ)) ? IDX_W'(sum - SUM_W'(NUM_REQ))
                                                     : IDX_W'(sum);
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Scan from the far end so the nearest candidate to rr_ptr wins.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        gnt_idx   = cand_idx[i];
        gnt_valid = 1'b1;
      end
    end
    gnt = gnt_valid ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/ei_axi4_wr_arbiter.sv
// ---------------------------------------------------------------------------
// ei_axi4_wr_arbiter
// AXI4 write-path arbiter: NUM_MST masters onto one slave port, one
// outstanding write at a time. AW is arbitrated round-robin; W and B stay
// locked to the granted master until its B handshake. W burst length is
// checked against AWLEN (data still forwarded unmodified, burst ends on wlast).
// Ports:
//   aclk     in   clock, posedge
//   areset   in   synchronous active-high reset
//   bus      if   ei_axi4_wr_arbiter_if.slave (all AW/W/B channels)
//   grant    out  current owner index, meaningful while busy
//   busy     out  high whenever the FSM is not in IDLE
//   err_len  out  one-cycle pulse, the cycle after a beat with a length
//                 mismatch; at most once per burst
// ---------------------------------------------------------------------------
module ei_axi4_wr_arbiter
  import ei_axi4_pkg::*;
#(
  parameter  int NUM_MST    = 4,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  parameter  int ID_WIDTH   = 4,
  localparam int IDX_W      = $clog2(NUM_MST)
) (
  input  logic                  aclk,
  input  logic                  areset,
  ei_axi4_wr_arbiter_if.slave   bus,
  output logic [IDX_W-1:0]      grant,
  output logic                  busy,
  output logic                  err_len
);
  localparam int AW_W = ID_WIDTH + ADDR_WIDTH + AW_FIXED_W;
  localparam int W_W  = DATA_WIDTH + DATA_WIDTH / 8;

  // ---------------- state ----------------
  arb_state_e         state_q,      state_d;
  logic [IDX_W-1:0]   grant_q,      grant_d;
  logic [NUM_MST-1:0] owner_oh_q,   owner_oh_d;
  logic [IDX_W-1:0]   rr_ptr_q,     rr_ptr_d;
  logic               busy_q,       busy_d;
  logic               err_len_q,    err_len_d;
  logic               err_seen_q,   err_seen_d;
  logic [7:0]         awlen_q,      awlen_d;
  logic [7:0]         beat_cnt_q,   beat_cnt_d;

  // ---------------- per-master payload unpacking ----------------
  logic [AW_W-1:0] aw_arr [NUM_MST];
  logic [W_W-1:0]  w_arr  [NUM_MST];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MST; gi++) begin : g_unpack
      assign aw_arr[gi] = bus.s_aw[gi*AW_W +: AW_W];
      assign w_arr[gi]  = bus.s_w[gi*W_W +: W_W];
    end
  endgenerate

  // ---------------- owner muxes (combinational, zero added latency) -------
  logic [AW_W-1:0] aw_sel;
  logic [W_W-1:0]  w_sel;
  logic            own_awvalid;
  logic            own_wvalid;
  logic            own_wlast;
  logic            own_bready;

  assign aw_sel      = aw_arr[grant_q];
  assign w_sel       = w_arr[grant_q];
  assign own_awvalid = bus.s_awvalid[grant_q];
  assign own_wvalid  = bus.s_wvalid[grant_q];
  assign own_wlast   = bus.s_wlast[grant_q];
  assign own_bready  = bus.s_bready[grant_q];

  // ---------------- arbitration ----------------
  logic [NUM_MST-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_valid;

  ei_axi4_rr_arbiter #(
    .NUM_REQ (NUM_MST)
  ) u_rr (
    .req       (bus.s_awvalid),
    .rr_ptr    (rr_ptr_q),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  // ---------------- handshakes ----------------
  logic             aw_hs;
  logic             w_hs;
  logic             b_hs;
  logic [IDX_W-1:0] next_ptr;

  assign aw_hs    = (state_q == ST_ADDR) && own_awvalid && bus.m_awready;
  assign w_hs     = (state_q == ST_DATA) && own_wvalid  && bus.m_wready;
  assign b_hs     = (state_q == ST_RESP) && bus.m_bvalid && own_bready;
  // Next round starts just after the master that was served (wraps to 0).
  assign next_ptr = (grant_q == IDX_W'(NUM_MST - 1)) ? '0 : grant_q + 1'b1;

  // ---------------- channel routing ----------------
  // Every valid/ready is forced low outside the state that owns its channel.
  always_comb begin
    bus.s_awready = '0;
    bus.s_wready  = '0;
    bus.s_bvalid  = '0;
    bus.s_b       = '0;
    bus.m_awvalid = 1'b0;
    bus.m_aw      = '0;
    bus.m_wvalid  = 1'b0;
    bus.m_wlast   = 1'b0;
    bus.m_w       = '0;
    bus.m_bready  = 1'b0;
    case (state_q)
      ST_ADDR: begin
        bus.m_awvalid = own_awvalid;
        bus.m_aw      = aw_sel;
        bus.s_awready = owner_oh_q & {NUM_MST{bus.m_awready}};
      end
      ST_DATA: begin
        bus.m_wvalid  = own_wvalid;
        bus.m_wlast   = own_wlast;
        bus.m_w       = w_sel;
        bus.s_wready  = owner_oh_q & {NUM_MST{bus.m_wready}};
      end
      ST_RESP: begin
        bus.s_bvalid  = owner_oh_q & {NUM_MST{bus.m_bvalid}};
        bus.s_b       = bus.m_b;
        bus.m_bready  = own_bready;
      end
      default: ;
    endcase
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_oh_d = owner_oh_q;
    rr_ptr_d   = rr_ptr_q;
    busy_d     = busy_q;
    err_len_d  = 1'b0;
    err_seen_d = err_seen_q;
    awlen_d    = awlen_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d    = arb_idx;
          owner_oh_d = arb_gnt;
          busy_d     = 1'b1;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (aw_hs) begin
          awlen_d    = aw_sel[AW_LEN_LSB +: AW_LEN_W];
          beat_cnt_d = '0;
          err_seen_d = 1'b0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          // Report only the first bad beat of a burst.
          if (len_mismatch(own_wlast, beat_cnt_q, awlen_q) && !err_seen_q) begin
            err_len_d  = 1'b1;
            err_seen_d = 1'b1;
          end
          if (own_wlast) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (b_hs) begin
          rr_ptr_d = next_ptr;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      owner_oh_q <= '0;
      rr_ptr_q   <= '0;
      busy_q     <= 1'b0;
      err_len_q  <= 1'b0;
      err_seen_q <= 1'b0;
      awlen_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_oh_q <= owner_oh_d;
      rr_ptr_q   <= rr_ptr_d;
      busy_q     <= busy_d;
      err_len_q  <= err_len_d;
      err_seen_q <= err_seen_d;
      awlen_q    <= awlen_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign err_len = err_len_q;

endmodule

// File: tb/tb_ei_axi4_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ei_axi4_wr_arbiter
// Directed self-checking bench for ei_axi4_wr_arbiter (4 masters).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ei_axi4_wr_arbiter;
  import ei_axi4_pkg::*;

  localparam int NUM_MST    = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = 4;
  localparam int AW_W       = ID_WIDTH + ADDR_WIDTH + 13;
  localparam int W_W        = DATA_WIDTH + DATA_WIDTH / 8;

  logic       aclk   = 1'b0;
  logic       areset = 1'b1;
  logic [1:0] grant;
  logic       busy;
  logic       err_len;

  int n_checks = 0;
  int n_errors = 0;

  logic [W_W:0] exp_q [$];
  logic [W_W:0] mon_q [$];

  ei_axi4_wr_arbiter_if #(
    .NUM_MST(NUM_MST), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)
  ) bus ();

  ei_axi4_wr_arbiter #(
    .NUM_MST(NUM_MST), .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH)
  ) dut (
    .aclk    (aclk),
    .areset  (areset),
    .bus     (bus),
    .grant   (grant),
    .busy    (busy),
    .err_len (err_len)
  );

  always #5 aclk = ~aclk;

  // Every beat accepted by the downstream slave, in order.
  always @(negedge aclk) begin
    if (!areset && bus.m_wvalid && bus.m_wready) mon_q.push_back({bus.m_wlast, bus.m_w});
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic sb_check(input string tag);
    chk($sformatf("%s_beat_count", tag), 64'(mon_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < mon_q.size()) chk($sformatf("%s_beat%0d", tag, i), 64'(mon_q[i]), 64'(exp_q[i]));
    end
    exp_q.delete();
    mon_q.delete();
  endtask

  task automatic set_aw(input int m, input logic [3:0] id, input logic [31:0] addr,
                        input logic [7:0] len);
    bus.s_aw[m*AW_W +: AW_W] = {id, addr, len, 3'd2, 2'b01};
  endtask

  // One complete write from IDLE: AW, nbeats W beats (wlast on the final one),
  // B. Random stalls of 0..bp_max cycles on m_wready and s_bready.
  task automatic run_txn(input int m, input logic [3:0] mask, input logic [3:0] id,
                         input logic [31:0] addr, input logic [7:0] len, input int nbeats,
                         input logic [1:0] bresp, input int bp_max);
    logic [AW_W-1:0]    pl;
    logic [W_W-1:0]     wd;
    logic [NUM_MST-1:0] oh;
    bit                 seen;
    bit                 mism;
    bit                 is_last;
    int                 k;
    string              t;
    t  = $sformatf("m%0d", m);
    oh = 4'b0001 << m;
    pl = {id, addr, len, 3'd2, 2'b01};
    bus.s_aw[m*AW_W +: AW_W] = pl;
    bus.s_awvalid = mask | oh;
    settle();
    chk({t, "_awvalid_idle"}, 64'(bus.m_awvalid), 64'd0);
    step();
    settle();
    chk({t, "_grant"}, 64'(grant), 64'(m));
    chk({t, "_busy"}, 64'(busy), 64'd1);
    chk({t, "_m_awvalid"}, 64'(bus.m_awvalid), 64'd1);
    chk({t, "_m_aw"}, 64'(bus.m_aw), 64'(pl));
    chk({t, "_awready_held"}, 64'(bus.s_awready), 64'd0);
    bus.m_awready = 1'b1;
    settle();
    chk({t, "_s_awready"}, 64'(bus.s_awready), 64'(oh));
    step();
    bus.s_awvalid[m] = 1'b0;
    bus.m_awready    = 1'b0;
    seen = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      is_last = (b == nbeats - 1);
      wd = {$urandom(), 4'(b) ^ 4'hA};
      bus.s_w[m*W_W +: W_W] = wd;
      bus.s_wvalid[m] = 1'b1;
      bus.s_wlast[m]  = is_last;
      k = (bp_max > 0) ? int'($urandom_range(bp_max, 0)) : 0;
      for (int c = 0; c < k; c++) begin
        settle();
        chk({t, "_wready_stall"}, 64'(bus.s_wready), 64'd0);
        step();
      end
      bus.m_wready = 1'b1;
      settle();
      chk($sformatf("%s_m_w_b%0d", t, b), 64'(bus.m_w), 64'(wd));
      chk($sformatf("%s_m_wlast_b%0d", t, b), 64'(bus.m_wlast), 64'(is_last));
      chk($sformatf("%s_s_wready_b%0d", t, b), 64'(bus.s_wready), 64'(oh));
      exp_q.push_back({is_last, wd});
      step();
      bus.m_wready    = 1'b0;
      bus.s_wvalid[m] = 1'b0;
      bus.s_wlast[m]  = 1'b0;
      mism = is_last ? (b != int'(len)) : (b == int'(len));
      settle();
      chk($sformatf("%s_err_len_b%0d", t, b), 64'(err_len), 64'(mism && !seen));
      if (mism) seen = 1'b1;
      if (!is_last) chk($sformatf("%s_busy_b%0d", t, b), 64'(busy), 64'd1);
    end
    bus.m_b      = {id, bresp};
    bus.m_bvalid = 1'b1;
    settle();
    chk({t, "_s_bvalid"}, 64'(bus.s_bvalid), 64'(oh));
    chk({t, "_s_b"}, 64'(bus.s_b), 64'({id, bresp}));
    chk({t, "_bready_held"}, 64'(bus.m_bready), 64'd0);
    k = (bp_max > 0) ? int'($urandom_range(bp_max, 0)) : 0;
    for (int c = 0; c < k; c++) step();
    bus.s_bready[m] = 1'b1;
    settle();
    chk({t, "_m_bready"}, 64'(bus.m_bready), 64'd1);
    step();
    bus.m_bvalid    = 1'b0;
    bus.s_bready[m] = 1'b0;
    settle();
    chk({t, "_busy_after"}, 64'(busy), 64'd0);
    chk({t, "_s_bvalid_after"}, 64'(bus.s_bvalid), 64'd0);
    sb_check(t);
  endtask

  initial begin
    bus.s_awvalid = '0;
    bus.s_aw      = '0;
    bus.s_wvalid  = '0;
    bus.s_wlast   = '0;
    bus.s_w       = '0;
    bus.s_bready  = '0;
    bus.m_awready = 1'b0;
    bus.m_wready  = 1'b0;
    bus.m_bvalid  = 1'b0;
    bus.m_b       = '0;

    // ---- reset state ----
    repeat (3) step();
    areset = 1'b0;
    settle();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_err_len", 64'(err_len), 64'd0);
    chk("rst_m_awvalid", 64'(bus.m_awvalid), 64'd0);
    chk("rst_m_wvalid", 64'(bus.m_wvalid), 64'd0);
    chk("rst_s_awready", 64'(bus.s_awready), 64'd0);
    chk("rst_s_wready", 64'(bus.s_wready), 64'd0);
    chk("rst_s_bvalid", 64'(bus.s_bvalid), 64'd0);
    chk("rst_m_bready", 64'(bus.m_bready), 64'd0);

    // ---- single master 0, AWLEN=3, 4 beats, OKAY ----
    run_txn(0, 4'b0000, 4'h5, 32'h0000_1000, 8'd3, 4, BRESP_OKAY, 0);

    // ---- fresh reset, then all four request continuously: 0,1,2,3,0 ----
    areset = 1'b1;
    step();
    areset = 1'b0;
    for (int j = 0; j < NUM_MST; j++) set_aw(j, 4'(j + 8), 32'h2000_0000 + 32'(j), 8'd1);
    for (int r = 0; r < 5; r++) begin
      run_txn(r % NUM_MST, 4'b1111, 4'((r % NUM_MST) + 8), 32'h2000_0000 + 32'(r),
              8'd1, 2, BRESP_OKAY, 0);
    end
    bus.s_awvalid = '0;

    // ---- master 2, AWLEN=1 but wlast on its first beat -> err_len once ----
    run_txn(2, 4'b0000, 4'h2, 32'h0000_3000, 8'd1, 1, BRESP_SLVERR, 0);

    // ---- master 1, AWLEN=0 but wlast only on the second beat ----
    run_txn(1, 4'b0000, 4'h1, 32'h0000_4000, 8'd0, 2, BRESP_OKAY, 0);

    // ---- backpressure on m_wready / s_bready ----
    run_txn(3, 4'b0000, 4'h3, 32'h0000_5000, 8'd7, 8, BRESP_OKAY, 5);
    run_txn(0, 4'b0000, 4'h6, 32'h0000_6000, 8'd2, 3, BRESP_SLVERR, 5);

    // ---- reset during DATA at beat 2 (master 2 owns, rr_ptr=1) ----
    set_aw(2, 4'h7, 32'h0000_7000, 8'd4);
    bus.s_awvalid = 4'b0100;
    step();
    bus.m_awready = 1'b1;
    step();
    bus.s_awvalid = '0;
    bus.m_awready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bus.s_w[2*W_W +: W_W] = {32'hC0DE_0000 + 32'(b), 4'hF};
      bus.s_wvalid[2] = 1'b1;
      bus.m_wready    = 1'b1;
      exp_q.push_back({1'b0, 32'hC0DE_0000 + 32'(b), 4'hF});
      step();
    end
    bus.s_w[2*W_W +: W_W] = {32'hC0DE_0002, 4'hF};
    bus.m_wready = 1'b0;
    areset       = 1'b1;
    step();
    areset       = 1'b0;
    bus.s_wvalid = '0;
    settle();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_grant", 64'(grant), 64'd0);
    chk("abort_s_wready", 64'(bus.s_wready), 64'd0);
    chk("abort_s_awready", 64'(bus.s_awready), 64'd0);
    chk("abort_m_awvalid", 64'(bus.m_awvalid), 64'd0);
    chk("abort_m_wvalid", 64'(bus.m_wvalid), 64'd0);
    chk("abort_m_bready", 64'(bus.m_bready), 64'd0);
    sb_check("abort");

    // rr_ptr is back at 0: masters 0 and 3 both ask, 0 wins, then 3.
    set_aw(3, 4'h9, 32'h0000_9000, 8'd1);
    run_txn(0, 4'b1000, 4'h8, 32'h0000_8000, 8'd1, 2, BRESP_OKAY, 0);
    run_txn(3, 4'b0000, 4'h9, 32'h0000_9000, 8'd1, 2, BRESP_OKAY, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
